// File: rtl/tile_rom_arbiter_pkg.sv
// Shared constants and types for the tile/sprite ROM arbiter.
package tile_rom_arbiter_pkg;

  // Default ROM geometry: 16K words of 4:4:4 RGB.
  localparam int TILE_AW         = 14;
  localparam int TILE_DW         = 12;
  localparam int TILE_N_REQ      = 3;
  localparam int TILE_ROM_LAT    = 2;
  localparam int TILE_STARVE_MAX = 15;

  // Requester port assignment; port 0 is the fixed-priority renderer.
  localparam int REQ_VGA    = 0;
  localparam int REQ_WORLD  = 1;
  localparam int REQ_SPRITE = 2;

  // Which selection rule produced this cycle's grant.
  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_STARVE = 2'd1,
    GNT_PRIO   = 2'd2,
    GNT_RR     = 2'd3
  } gnt_src_e;

endpackage

// File: rtl/tile_rom_arbiter_if.sv
// Requester/ROM bundle. The master side is the surrounding system (requesters
// plus the ROM macro, which supplies rom_data); the slave side is the arbiter.
interface tile_rom_arbiter_if
  import tile_rom_arbiter_pkg::*;
#(
  parameter int N_REQ = TILE_N_REQ,
  parameter int AW    = TILE_AW,
  parameter int DW    = TILE_DW
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ-1:0]    gnt;
  logic                rom_en;
  logic [AW-1:0]       rom_addr;
  logic [DW-1:0]       rom_data;
  logic [DW-1:0]       rd_data;
  logic [N_REQ-1:0]    rd_valid;

  modport master (
    output req, addr, rom_data,
    input  gnt, rom_en, rom_addr, rd_data, rd_valid
  );

  modport slave (
    input  req, addr, rom_data,
    output gnt, rom_en, rom_addr, rd_data, rd_valid
  );
endinterface

// File: rtl/tile_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping modulo N. Produces a one-hot pick and a valid flag.
module tile_rom_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          vld
);

  // Scan N positions starting at ptr; the first requester found wins.
  always_comb begin
    int j;
    pick = '0;
    vld  = 1'b0;
    j    = 0;
    for (int off = 0; off < N; off++) begin
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      if (!vld && req[j]) begin
        pick[j] = 1'b1;
        vld     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_rom_arbiter.sv
// Single-port tile ROM arbiter: port 0 has fixed priority, ports 1.. are
// round-robin, and per-port wait counters force a grant once a low-priority
// requester has waited STARVE_MAX cycles. A one-hot tag pipeline routes the
// read data back ROM_LAT cycles after the registered ROM access.
module tile_rom_arbiter
  import tile_rom_arbiter_pkg::*;
#(
  parameter int N_REQ      = TILE_N_REQ,
  parameter int AW         = TILE_AW,
  parameter int DW         = TILE_DW,
  parameter int ROM_LAT    = TILE_ROM_LAT,
  parameter int STARVE_MAX = TILE_STARVE_MAX
) (
  input  logic               clk,
  input  logic               rst,
  tile_rom_arbiter_if.slave  bus,
  output logic               starve_evt
);

  localparam int CW  = $clog2(STARVE_MAX + 1);
  localparam int PW  = $clog2(N_REQ);
  localparam int NLO = N_REQ - 1;
  localparam int PPW = (NLO > 1) ? $clog2(NLO) : 1;

  logic [N_REQ-1:1][CW-1:0]     wait_cnt;
  logic [PW-1:0]                rr_ptr, rr_nxt;
  logic [ROM_LAT:0][N_REQ-1:0]  tag_pipe;
  logic                         rom_en_q, starve_q;
  logic [AW-1:0]                rom_addr_q, sel_addr;
  logic [N_REQ-1:0]             gnt, starve_oh;
  logic [NLO-1:0]               rr_oh;
  logic                         rr_vld;
  logic [PPW-1:0]               ptr_lo;
  gnt_src_e                     src;

  // rr_ptr counts 1..N_REQ-1; the picker indexes the low-priority slice from 0.
  assign ptr_lo = PPW'(rr_ptr - PW'(1));

  tile_rom_arbiter_rr_pick #(.N(NLO), .PW(PPW)) u_rr_pick (
    .req  (bus.req[N_REQ-1:1]),
    .ptr  (ptr_lo),
    .pick (rr_oh),
    .vld  (rr_vld)
  );

  // Grant selection: starvation override, then port 0, then round-robin.
  always_comb begin
    gnt       = '0;
    starve_oh = '0;
    src       = GNT_NONE;
    // Descending scan so the lowest starving index is the one left standing.
    for (int i = N_REQ - 1; i >= 1; i--) begin
      if (bus.req[i] && wait_cnt[i] == CW'(STARVE_MAX)) begin
        starve_oh    = '0;
        starve_oh[i] = 1'b1;
      end
    end
    if (!rst) begin
      if (|starve_oh) begin
        gnt = starve_oh;
        src = GNT_STARVE;
      end else if (bus.req[0]) begin
        gnt[0] = 1'b1;
        src    = GNT_PRIO;
      end else if (rr_vld) begin
        gnt = {rr_oh, 1'b0};
        src = GNT_RR;
      end
    end
  end

  // Address of the winning requester.
  always_comb begin
    sel_addr = '0;
    for (int k = 0; k < N_REQ; k++)
      if (gnt[k]) sel_addr = bus.addr[k*AW +: AW];
  end

  // Next round-robin pointer: one past a low-priority winner, wrapping to 1.
  always_comb begin
    rr_nxt = rr_ptr;
    for (int k = 1; k < N_REQ; k++)
      if (gnt[k]) rr_nxt = (k == N_REQ - 1) ? PW'(1) : PW'(k + 1);
  end

  // ROM access registers, starvation pulse and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      starve_q   <= 1'b0;
      rr_ptr     <= PW'(1);
    end else begin
      rom_en_q <= |gnt;
      if (|gnt) rom_addr_q <= sel_addr;
      starve_q <= (src == GNT_STARVE);
      rr_ptr   <= rr_nxt;
    end
  end

  // Tag pipeline: the one-hot grant travels alongside the ROM read.
  always_ff @(posedge clk) begin
    if (rst) tag_pipe <= '0;
    else     tag_pipe <= {tag_pipe[ROM_LAT-1:0], gnt};
  end

  // Wait counters: count ungranted request cycles, saturating; clear otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else begin
      for (int i = 1; i < N_REQ; i++) begin
        if (!bus.req[i] || gnt[i])
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != CW'(STARVE_MAX))
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  // Outputs are held quiet for the whole reset cycle, including any access
  // that was registered just before reset rose; its return is dropped.
  assign bus.gnt      = gnt;
  assign bus.rom_en   = rom_en_q & ~rst;
  assign bus.rom_addr = rst ? '0 : rom_addr_q;
  assign bus.rd_valid = rst ? '0 : tag_pipe[ROM_LAT];
  assign bus.rd_data  = bus.rom_data;
  assign starve_evt   = starve_q & ~rst;

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Self-checking bench for tile_rom_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_tile_rom_arbiter;
  import tile_rom_arbiter_pkg::*;

  localparam int N    = 3;
  localparam int AW   = 14;
  localparam int DW   = 12;
  localparam int LAT  = 2;
  localparam int SMAX = 15;

  logic clk = 1'b0;
  logic rst;
  logic starve_evt;
  always #5 clk = ~clk;

  tile_rom_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus();

  tile_rom_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .ROM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .starve_evt (starve_evt)
  );

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[11:0] ^ 12'hB9F ^ {10'd0, a[13:12]};
  endfunction

  // ROM model: data for the address presented in cycle c is on rom_data in c+LAT.
  logic [DW-1:0] rpipe [LAT];
  always @(posedge clk) begin
    rpipe[0] <= rom_fn(bus.rom_addr);
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.rom_data = rpipe[LAT-1];

  typedef struct {
    int            due;
    int            who;
    logic [AW-1:0] a;
  } ret_t;

  int            checks = 0, failures = 0;
  int            mwait [N];
  int            mptr;
  logic          exp_en, exp_starve;
  logic [AW-1:0] exp_addr;
  ret_t          q [$];
  int            cyc = 0;

  logic [N-1:0]  obs_gnt, obs_rdv;
  logic [DW-1:0] obs_rdd;
  logic          obs_en, obs_starve;
  logic [AW-1:0] obs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check every output against the model,
  // then advance the model past the next rising edge.
  task automatic step(input logic r, input logic [N-1:0] rq,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    logic [AW-1:0] av [N];
    int            g;
    logic          st;
    logic [N-1:0]  ev;
    logic [DW-1:0] ed;
    @(negedge clk);
    rst = r; bus.req = rq; bus.addr = {a2, a1, a0};
    av[0] = a0; av[1] = a1; av[2] = a2;
    #1;
    obs_gnt = bus.gnt; obs_rdv = bus.rd_valid; obs_rdd = bus.rd_data;
    obs_en = bus.rom_en; obs_addr = bus.rom_addr; obs_starve = starve_evt;
    if (r) begin
      chk("rst_gnt", obs_gnt, 0);
      chk("rst_rom_en", obs_en, 0);
      chk("rst_rom_addr", obs_addr, 0);
      chk("rst_rd_valid", obs_rdv, 0);
      chk("rst_starve", obs_starve, 0);
      for (int i = 0; i < N; i++) mwait[i] = 0;
      mptr = 1; exp_en = 0; exp_addr = '0; exp_starve = 0;
      q.delete();
    end else begin
      g = -1; st = 0;
      for (int i = 1; i < N && g < 0; i++)
        if (rq[i] && mwait[i] >= SMAX) begin g = i; st = 1; end
      if (g < 0 && rq[0]) g = 0;
      for (int off = 0; off < N - 1 && g < 0; off++) begin
        int j;
        j = 1 + ((mptr - 1 + off) % (N - 1));
        if (rq[j]) g = j;
      end
      chk("gnt", obs_gnt, (g < 0) ? 0 : (1 << g));
      chk("rom_en", obs_en, exp_en);
      chk("rom_addr", obs_addr, exp_addr);
      chk("starve_evt", obs_starve, exp_starve);
      ev = '0; ed = '0;
      foreach (q[i]) if (q[i].due == cyc) begin ev = N'(1 << q[i].who); ed = rom_fn(q[i].a); end
      chk("rd_valid", obs_rdv, ev);
      if (ev != 0) chk("rd_data", obs_rdd, ed);
      exp_en = (g >= 0);
      exp_starve = st;
      if (g >= 0) begin
        ret_t e;
        exp_addr = av[g];
        e.due = cyc + 1 + LAT; e.who = g; e.a = av[g];
        q.push_back(e);
        if (g >= 1) mptr = (g == N - 1) ? 1 : g + 1;
      end
      for (int i = 1; i < N; i++)
        mwait[i] = (rq[i] && g != i) ? ((mwait[i] < SMAX) ? mwait[i] + 1 : SMAX) : 0;
    end
    cyc++;
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
  endtask

  initial begin
    int n1, n2, hit;
    logic [N-1:0]  prev, rq;
    logic [AW-1:0] ra [N];
    rst = 1'b1; bus.req = '0; bus.addr = '0;
    step(1, 3'b000, 0, 0, 0);
    step(1, 3'b000, 0, 0, 0);

    // Single read on port 1.
    step(0, 3'b010, 0, 14'h0123, 0);
    chk("t1_gnt", obs_gnt, 3'b010);
    step(0, 3'b000, 0, 0, 0);
    chk("t1_rom_en", obs_en, 1);
    chk("t1_rom_addr", obs_addr, 14'h0123);
    step(0, 3'b000, 0, 0, 0);
    step(0, 3'b000, 0, 0, 0);
    chk("t1_rd_valid", obs_rdv, 3'b010);
    chk("t1_rd_data", obs_rdd, 12'hABC);

    // Port 0 priority, then round-robin from a fresh pointer.
    step(1, 3'b000, 0, 0, 0);
    step(0, 3'b111, 14'h10, 14'h11, 14'h12);
    chk("prio_gnt", obs_gnt, 3'b001);
    step(0, 3'b110, 14'h10, 14'h11, 14'h12);
    chk("rr_first", obs_gnt, 3'b010);
    step(0, 3'b110, 14'h10, 14'h11, 14'h12);
    chk("rr_second", obs_gnt, 3'b100);

    // Fairness between ports 1 and 2.
    n1 = 0; n2 = 0; prev = 3'b100;
    for (int k = 0; k < 10; k++) begin
      step(0, 3'b110, 0, 14'h21, 14'h22);
      chk("rr_alternate", obs_gnt, (prev == 3'b010) ? 3'b100 : 3'b010);
      prev = obs_gnt;
      if (obs_gnt == 3'b010) n1++;
      if (obs_gnt == 3'b100) n2++;
    end
    chk("rr_count1", n1, 5);
    chk("rr_count2", n2, 5);

    // Starvation override against continuous port 0 traffic.
    step(0, 3'b000, 0, 0, 0);
    hit = -1;
    for (int k = 0; k < 40 && hit < 0; k++) begin
      step(0, 3'b101, 14'h30, 0, 14'h32);
      if (obs_gnt == 3'b100) hit = k;
    end
    chk("starve_cycle", hit, SMAX);
    step(0, 3'b101, 14'h30, 0, 14'h32);
    chk("starve_pulse", obs_starve, 1);
    chk("starve_resume_p0", obs_gnt, 3'b001);
    step(0, 3'b101, 14'h30, 0, 14'h32);
    chk("starve_pulse_once", obs_starve, 0);
    step(0, 3'b000, 0, 0, 0);
    step(0, 3'b000, 0, 0, 0);
    step(0, 3'b000, 0, 0, 0);

    // Reset while a read is in flight.
    step(0, 3'b010, 0, 14'h0456, 0);
    step(1, 3'b000, 0, 0, 0);
    chk("midrst_rom_en", obs_en, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 3'b000, 0, 0, 0);
      chk("midrst_no_valid", obs_rdv, 0);
    end

    // Back-to-back reads on port 0.
    for (int k = 0; k < 8; k++) begin
      step(0, (k < 4) ? 3'b001 : 3'b000, (k < 4) ? AW'(k) : AW'(0), 0, 0);
      if (k >= 1 && k <= 4) begin
        chk("b2b_rom_en", obs_en, 1);
        chk("b2b_rom_addr", obs_addr, k - 1);
      end
      if (k >= 3 && k <= 6) begin
        chk("b2b_rd_valid", obs_rdv, 3'b001);
        chk("b2b_rd_data", obs_rdd, rom_fn(AW'(k - 3)));
      end
    end

    // Randomized traffic: low-priority requests held until granted,
    // port 0 busy most of the time so starvation overrides occur.
    rq = '0;
    for (int i = 0; i < N; i++) ra[i] = '0;
    for (int k = 0; k < 600; k++) begin
      logic r;
      r = ($urandom_range(0, 99) == 0);
      rq[0] = ($urandom_range(0, 9) != 0);
      ra[0] = AW'($urandom);
      for (int i = 1; i < N; i++) begin
        if (!rq[i] && $urandom_range(0, 2) == 0) begin
          rq[i] = 1'b1;
          ra[i] = AW'($urandom);
        end
      end
      step(r, rq, ra[0], ra[1], ra[2]);
      for (int i = 1; i < N; i++) if (r || obs_gnt[i]) rq[i] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
